// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - default geometry (log2 bytes per line, log2 number of sets)
//   - controller state encoding
//   - address field extraction helpers (tag / set index)
// The helpers take the geometry as arguments so that a cache instance built
// with non-default parameters extracts its fields consistently.
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int DEF_S_OFFSET = 5;   // 32-byte / 256-bit line
    localparam int DEF_S_INDEX  = 4;   // 16 sets

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Tag field, right-justified and zero-extended to 32 bits.
    function automatic logic [31:0] addr_tag(
        input logic [31:0] addr,
        input int          s_index,
        input int          s_offset
    );
        return addr >> (s_index + s_offset);
    endfunction

    // Set index field, right-justified and zero-extended to 32 bits.
    function automatic logic [31:0] addr_index(
        input logic [31:0] addr,
        input int          s_index,
        input int          s_offset
    );
        return (addr >> s_offset) & ((32'd1 << s_index) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
// Flop-based storage array with one synchronous write port and one
// combinational read port. Used for the tag, data and valid arrays.
//
// Parameters:
//   WIDTH     - bits per entry
//   DEPTH     - number of entries
//   RESET_EN  - 1: every entry clears to zero on rst; 0: contents untouched
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (only effective with RESET_EN)
//   we     in   write enable, sampled at posedge
//   waddr  in   write entry
//   wdata  in   write data
//   raddr  in   read entry
//   rdata  out  read data (combinational)
// -----------------------------------------------------------------------------
module icache_array #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 16,
    parameter bit RESET_EN = 1'b0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage update: optional clear on reset, otherwise write on we.
    // A non-resettable array simply skips writes during the reset cycle.
    always_ff @(posedge clk) begin
        if (RESET_EN && rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (!rst && we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
// Read-only, direct-mapped instruction cache between the CPU fetch port and
// line-granular physical memory. Hits are answered in the same cycle the
// request is presented; a miss fetches a whole line, installs it, and the
// request is then answered from the cache on the following IDLE cycle.
//
// Optional build macro: ICACHE_PERF_CNT_EN
//   When defined, adds saturating hit_count / miss_count outputs.
//
// Ports:
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   imem_address  in   CPU fetch byte address (bits [1:0] ignored)
//   imem_read     in   CPU fetch request, level-sensitive
//   imem_rdata    out  instruction word, zero unless imem_resp
//   imem_resp     out  fetch completes this cycle
//   pmem_address  out  line-aligned miss address, zero when not filling
//   pmem_read     out  line read request, held until pmem_resp
//   pmem_rdata    in   returned line
//   pmem_resp     in   line valid this cycle (single-cycle pulse)
//   hit_count     out  (ICACHE_PERF_CNT_EN) cycles answered from the cache
//   miss_count    out  (ICACHE_PERF_CNT_EN) fills started
// -----------------------------------------------------------------------------
module icache_direct
    import icache_pkg::*;
#(
    parameter int S_OFFSET  = DEF_S_OFFSET,
    parameter int S_INDEX   = DEF_S_INDEX,
    localparam int S_TAG    = 32 - S_INDEX - S_OFFSET,
    localparam int S_LINE   = 8 * (2 ** S_OFFSET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       imem_address,
    input  logic              imem_read,
    output logic [31:0]       imem_rdata,
    output logic              imem_resp,
    output logic [31:0]       pmem_address,
    output logic              pmem_read,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int S_WORDS = 2 ** (S_OFFSET - 2);
    localparam int S_WSEL  = S_OFFSET - 2;
    localparam int S_DEPTH = 2 ** S_INDEX;

    icache_state_t        state_r;
    logic                 pmem_read_r;
    logic [31:0]          miss_addr_r;

    logic [31:0]          rd_tag_full_s;
    logic [31:0]          rd_idx_full_s;
    logic [31:0]          wr_tag_full_s;
    logic [31:0]          wr_idx_full_s;
    logic [S_TAG-1:0]     rd_tag_s;
    logic [S_INDEX-1:0]   rd_idx_s;
    logic [S_TAG-1:0]     wr_tag_s;
    logic [S_INDEX-1:0]   wr_idx_s;
    logic [S_WSEL-1:0]    wsel_s;

    logic [S_TAG-1:0]     tag_rd_s;
    logic [S_LINE-1:0]    line_rd_s;
    logic                 valid_rd_s;
    logic [31:0]          words_s [S_WORDS];

    logic                 fill_we_s;
    logic                 hit_s;
    logic                 miss_start_s;
    logic [31:0]          rdata_s;
    logic                 unused_bits_s;

    // Field extraction: read side follows the live CPU address, write side
    // follows the latched miss address so a redirect cannot misplace a fill.
    assign rd_tag_full_s = addr_tag(imem_address, S_INDEX, S_OFFSET);
    assign rd_idx_full_s = addr_index(imem_address, S_INDEX, S_OFFSET);
    assign wr_tag_full_s = addr_tag(miss_addr_r, S_INDEX, S_OFFSET);
    assign wr_idx_full_s = addr_index(miss_addr_r, S_INDEX, S_OFFSET);
    assign rd_tag_s      = rd_tag_full_s[S_TAG-1:0];
    assign rd_idx_s      = rd_idx_full_s[S_INDEX-1:0];
    assign wr_tag_s      = wr_tag_full_s[S_TAG-1:0];
    assign wr_idx_s      = wr_idx_full_s[S_INDEX-1:0];
    assign wsel_s        = imem_address[S_OFFSET-1:2];

    assign unused_bits_s = ^{rd_tag_full_s[31:S_TAG], rd_idx_full_s[31:S_INDEX],
                             wr_tag_full_s[31:S_TAG], wr_idx_full_s[31:S_INDEX],
                             imem_address[1:0]};

    assign fill_we_s = (state_r == FILL) && pmem_resp;

    icache_array #(.WIDTH(S_TAG), .DEPTH(S_DEPTH), .RESET_EN(1'b0)) u_tag (
        .clk   (clk),
        .rst   (rst),
        .we    (fill_we_s),
        .waddr (wr_idx_s),
        .wdata (wr_tag_s),
        .raddr (rd_idx_s),
        .rdata (tag_rd_s)
    );

    icache_array #(.WIDTH(S_LINE), .DEPTH(S_DEPTH), .RESET_EN(1'b0)) u_data (
        .clk   (clk),
        .rst   (rst),
        .we    (fill_we_s),
        .waddr (wr_idx_s),
        .wdata (pmem_rdata),
        .raddr (rd_idx_s),
        .rdata (line_rd_s)
    );

    icache_array #(.WIDTH(1), .DEPTH(S_DEPTH), .RESET_EN(1'b1)) u_valid (
        .clk   (clk),
        .rst   (rst),
        .we    (fill_we_s),
        .waddr (wr_idx_s),
        .wdata (1'b1),
        .raddr (rd_idx_s),
        .rdata (valid_rd_s)
    );

    // Hit detection: only IDLE answers requests; reset suppresses responses
    // because valid bits may still be set during the reset cycle.
    always_comb begin
        hit_s        = 1'b0;
        miss_start_s = 1'b0;
        if (!rst && (state_r == IDLE) && imem_read) begin
            if (valid_rd_s && (tag_rd_s == rd_tag_s)) begin
                hit_s = 1'b1;
            end else begin
                miss_start_s = 1'b1;
            end
        end else begin
            hit_s        = 1'b0;
            miss_start_s = 1'b0;
        end
    end

    // Split the selected line into 32-bit words for the word mux.
    always_comb begin
        for (int w = 0; w < S_WORDS; w++) begin
            words_s[w] = line_rd_s[w*32 +: 32];
        end
    end

    // Word select; output is forced to zero whenever there is no response.
    always_comb begin
        rdata_s = 32'd0;
        if (hit_s) begin
            rdata_s = words_s[wsel_s];
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign imem_resp    = hit_s;
    assign imem_rdata   = rdata_s;
    assign pmem_read    = pmem_read_r;
    assign pmem_address = miss_addr_r;

    // Miss controller: latches the line address on a miss and holds the
    // memory request until the line returns. pmem_resp outside FILL is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pmem_read_r <= 1'b0;
            miss_addr_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss_start_s) begin
                        state_r     <= FILL;
                        pmem_read_r <= 1'b1;
                        miss_addr_r <= {imem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state_r     <= IDLE;
                        pmem_read_r <= 1'b0;
                        miss_addr_r <= 32'd0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pmem_read_r <= 1'b0;
                    miss_addr_r <= 32'd0;
                end
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating event counters for hits and fill starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if (hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (miss_start_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// -----------------------------------------------------------------------------
// tb_icache_direct
// Scoreboard bench for icache_direct. Stimulus pushes expected CPU words and
// expected memory line addresses into queues; a CPU-side monitor and a memory
// model pop and compare as the DUT presents responses/requests.
// Memory line contents: word i of line L = {16'hC0DE, (L + 4*i)[15:0]}, so the
// expected word for byte address A is {16'hC0DE, A[15:2], 2'b00}.
// -----------------------------------------------------------------------------
module tb_icache_direct;

    logic         clk;
    logic         rst;
    logic [31:0]  imem_address;
    logic         imem_read;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    icache_direct dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    int checks = 0;
    int passes = 0;

    logic [31:0] data_q [$];
    logic [31:0] pmem_q [$];

    logic mem_auto    = 1'b1;
    logic stale_pulse = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = {16'hC0DE, la[15:0] + 16'(i * 4)};
        end
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    // CPU-side monitor: every response must match the oldest expected word,
    // and rdata must be zero whenever there is no response.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_resp === 1'b1) begin
                if (data_q.size() == 0) begin
                    check("unexpected_resp", imem_rdata, 32'hXXXX_XXXX);
                end else begin
                    check("imem_rdata", imem_rdata, data_q.pop_front());
                end
            end else begin
                check("rdata_zero_no_resp", imem_rdata, 32'd0);
            end
        end
    end

    // Memory model: 3-cycle latency, checks each new request address.
    initial begin
        logic busy;
        int   cnt;
        busy      = 1'b0;
        cnt       = 0;
        pmem_resp = 1'b0;
        pmem_rdata = 256'd0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (stale_pulse) begin
                pmem_resp   = 1'b1;
                pmem_rdata  = {8{32'hDEAD_BEEF}};
                stale_pulse = 1'b0;
            end else if (mem_auto && pmem_read) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    if (pmem_q.size() == 0) begin
                        check("unexpected_pmem_read", pmem_address, 32'hXXXX_XXXX);
                    end else begin
                        check("pmem_address", pmem_address, pmem_q.pop_front());
                    end
                end
                cnt++;
                if (cnt == 3) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = make_line(pmem_address);
                    busy       = 1'b0;
                end
            end
        end
    end

    // Wait for a CPU response (bounded) and check the latency in cycles,
    // counting the current cycle as 1. Leaves time at posedge+1.
    task automatic wait_resp(input string name, input int exp_lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (imem_resp === 1'b1) begin
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (got) begin
            check(name, 32'(n), 32'(exp_lat));
        end else begin
            check({name, "_timeout"}, 32'(n), 32'(exp_lat));
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input bit miss, input int exp_lat);
        imem_address = addr;
        imem_read    = 1'b1;
        data_q.push_back(exp_word(addr));
        if (miss) begin
            pmem_q.push_back({addr[31:5], 5'b00000});
        end
        wait_resp("latency", exp_lat);
        imem_read = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        imem_read    = 1'b0;
        imem_address = 32'h0000_0060;
        repeat (3) @(posedge clk);
        #1;
        check("reset_imem_resp", {31'd0, imem_resp}, 32'd0);
        check("reset_pmem_read", {31'd0, pmem_read}, 32'd0);
        check("reset_pmem_address", pmem_address, 32'd0);
        rst = 1'b0;

        // Idle with a valid-looking address: nothing happens.
        repeat (3) begin
            @(negedge clk);
            check("idle_no_resp", {31'd0, imem_resp}, 32'd0);
            check("idle_no_pmem", {31'd0, pmem_read}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Cold miss then same-cycle hits.
        fetch(32'h0000_0060, 1'b1, 5);
        fetch(32'h0000_0064, 1'b0, 1);
`ifdef ICACHE_PERF_CNT_EN
        check("miss_count", miss_count, 32'd1);
        check("hit_count", hit_count, 32'd2);
`endif
        fetch(32'h0000_0063, 1'b0, 1);
        fetch(32'h0000_007C, 1'b0, 1);

        // Conflict eviction on index 3.
        fetch(32'h0000_0260, 1'b1, 5);
        fetch(32'h0000_0060, 1'b1, 5);

        // Redirect two cycles into the fill of 0x100.
        imem_address = 32'h0000_0100;
        imem_read    = 1'b1;
        pmem_q.push_back(32'h0000_0100);
        pmem_q.push_back(32'h0000_0400);
        data_q.push_back(exp_word(32'h0000_0400));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        imem_address = 32'h0000_0400;
        wait_resp("redirect_latency", 7);
        imem_read = 1'b0;
        fetch(32'h0000_0100, 1'b0, 1);

        // Request dropped during the fill: the line is still installed.
        imem_address = 32'h0000_0180;
        imem_read    = 1'b1;
        pmem_q.push_back(32'h0000_0180);
        @(posedge clk);
        #1;
        imem_read = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("dropped_fill_done", {31'd0, pmem_read}, 32'd0);
        fetch(32'h0000_0180, 1'b0, 1);

        // Reset in the middle of a fill, then a stale memory response.
        mem_auto     = 1'b0;
        imem_address = 32'h0000_03E0;
        imem_read    = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("fill_pmem_read", {31'd0, pmem_read}, 32'd1);
        check("fill_pmem_address", pmem_address, 32'h0000_03E0);
        rst       = 1'b1;
        imem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_fill_pmem_read", {31'd0, pmem_read}, 32'd0);
        check("rst_fill_pmem_address", pmem_address, 32'd0);
        check("rst_fill_imem_resp", {31'd0, imem_resp}, 32'd0);
        stale_pulse = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stale_resp_ignored", {31'd0, pmem_read}, 32'd0);
        mem_auto = 1'b1;
        fetch(32'h0000_0100, 1'b1, 5);
        fetch(32'h0000_03E0, 1'b1, 5);

        repeat (2) @(posedge clk);
        #1;
        check("data_q_empty", 32'(data_q.size()), 32'd0);
        check("pmem_q_empty", 32'(pmem_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
